ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 150 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: elastic FIFO of DEPTH words with 4-phase req/ack handshakes on both sides.
// Optional macro CTRL_PIPE_STATUS_EN adds registered level/full/empty outputs.
module ctrl_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_in,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_out,
    output logic             ctrl_out
`ifdef CTRL_PIPE_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_t;

    in_state_t        r_in_state;
    in_state_t        w_in_next;
    out_state_t       r_out_state;
    out_state_t       w_out_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_wr_next;
    logic [AW:0]      w_rd_next;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_load;
    logic             w_pop;
    logic             r_ctrl;
    logic [WIDTH-1:0] r_data_out;

    // Same index with differing wrap bits means every entry is occupied.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_wr_next = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_rd_next = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    always_comb begin
        w_in_next = r_in_state;
        w_push    = 1'b0;
        case (r_in_state)
            IN_IDLE: begin
                if (req_in && !w_full) begin
                    w_push    = 1'b1;
                    w_in_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!req_in) begin
                    w_in_next = IN_IDLE;
                end
            end
            default: w_in_next = IN_IDLE;
        endcase
    end

    always_comb begin
        w_out_next = r_out_state;
        w_load     = 1'b0;
        w_pop      = 1'b0;
        case (r_out_state)
            OUT_IDLE: begin
                if (!w_empty && !ack_out) begin
                    w_load     = 1'b1;
                    w_out_next = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_out) begin
                    w_pop      = 1'b1;
                    w_out_next = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!ack_out) begin
                    w_out_next = OUT_IDLE;
                end
            end
            default: w_out_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ctrl      <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_in_state  <= w_in_next;
            r_out_state <= w_out_next;
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_ctrl      <= w_push;
            if (w_load) begin
                r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        end
    end

    assign ack_in   = (r_in_state == IN_ACK);
    assign req_out  = (r_out_state == OUT_REQ);
    assign data_out = r_data_out;
    assign ctrl_out = r_ctrl;

`ifdef CTRL_PIPE_STATUS_EN
    localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};
    logic [AW:0] w_level_next;

    assign w_level_next = w_wr_next - w_rd_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            level <= w_level_next;
            full  <= (w_level_next == LVL_FULL);
            empty <= (w_level_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: queue-based reference model, randomized 4-phase agents.
// Status outputs are checked only when CTRL_PIPE_STATUS_EN is defined.
module tb_ctrl_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_in = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             ack_out = 1'b0;
    logic             ack_in;
    logic             req_out;
    logic [WIDTH-1:0] data_out;
    logic             ctrl_out;
`ifdef CTRL_PIPE_STATUS_EN
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic                   empty;
`endif

    ctrl_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_out  (ack_out),
        .ctrl_out (ctrl_out)
`ifdef CTRL_PIPE_STATUS_EN
        ,
        .level    (level),
        .full     (full),
        .empty    (empty)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the handshake phase of each side.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ack_in = 1'b0;
    int               m_ph = 0;
    bit               m_ctrl = 1'b0;
    logic [WIDTH-1:0] m_dout = '0;
    int               m_occ;
    bit               m_push;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_ack_in = 1'b0;
            m_ph     = 0;
            m_ctrl   = 1'b0;
            m_dout   = '0;
        end else begin
            m_occ  = m_q.size();
            m_push = !m_ack_in && req_in && (m_occ < DEPTH);
            m_ctrl = m_push;
            if (m_ack_in && !req_in) m_ack_in = 1'b0;
            else if (m_push) m_ack_in = 1'b1;
            case (m_ph)
                0: if (m_occ > 0 && !ack_out) begin m_dout = m_q[0]; m_ph = 1; end
                1: if (ack_out) begin void'(m_q.pop_front()); m_ph = 2; end
                default: if (!ack_out) m_ph = 0;
            endcase
            if (m_push) m_q.push_back(data_in);
        end
    end

    bit chk_en = 1'b0;
    int ctrl_cnt = 0;
    int max_occ = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack_in", 32'(ack_in), 32'(m_ack_in));
            check("req_out", 32'(req_out), 32'(m_ph == 1));
            check("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
            if (m_ph == 1) check("data_out", 32'(data_out), 32'(m_dout));
`ifdef CTRL_PIPE_STATUS_EN
            check("level", 32'(level), 32'(m_q.size()));
            check("full", 32'(full), 32'(m_q.size() == DEPTH));
            check("empty", 32'(empty), 32'(m_q.size() == 0));
`endif
            if (ctrl_out === 1'b1) ctrl_cnt++;
            if (m_q.size() > max_occ) max_occ = m_q.size();
        end
    end

    // Downstream agent: acks each offered word after a random delay and logs it.
    bit               sink_en = 1'b0;
    int               sink_max = 0;
    int               sink_wait = 0;
    logic [WIDTH-1:0] got[$];

    always @(negedge clk) begin
        if (sink_en) begin
            if (req_out === 1'b1 && !ack_out) begin
                if (sink_wait > 0) sink_wait--;
                else begin
                    got.push_back(data_out);
                    ack_out   = 1'b1;
                    sink_wait = int'($urandom_range(0, sink_max));
                end
            end else if (req_out === 1'b0 && ack_out) begin
                if (sink_wait > 0) sink_wait--;
                else begin
                    ack_out   = 1'b0;
                    sink_wait = int'($urandom_range(0, sink_max));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int maxd);
        int n;
        cycles(int'($urandom_range(0, maxd)));
        req_in  = 1'b1;
        data_in = d;
        n = 0;
        do begin @(negedge clk); n++; end while (ack_in !== 1'b1 && n < 200);
        if (ack_in !== 1'b1) check("send_ack_timeout", 32'(ack_in), 32'd1);
        req_in = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (ack_in !== 1'b0 && n < 200);
        if (ack_in !== 1'b0) check("send_release_timeout", 32'(ack_in), 32'd0);
    endtask

    task automatic wait_got(input int n, input string nm);
        int k;
        k = 0;
        while (got.size() < n && k < 600) begin @(negedge clk); k++; end
        check(nm, 32'(got.size()), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, ack_in=%0b req_out=%0b", ack_in, req_out);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int c0;
        logic [WIDTH-1:0] sent[$];
        logic [WIDTH-1:0] exp_fill[4];

        // Reset state
        rst = 1'b1;
        cycles(2);
        check("rst_ack_in", 32'(ack_in), 32'd0);
        check("rst_req_out", 32'(req_out), 32'd0);
        check("rst_ctrl_out", 32'(ctrl_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h0);
`ifdef CTRL_PIPE_STATUS_EN
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
`endif
        rst    = 1'b0;
        chk_en = 1'b1;
        cycles(1);

        // Single word with latency
        c0 = ctrl_cnt;
        g0 = got.size();
        req_in  = 1'b1;
        data_in = 8'hA5;
        cycles(1);
        check("lat_ack_in", 32'(ack_in), 32'd1);
        check("lat_req_out_early", 32'(req_out), 32'd0);
        cycles(1);
        check("lat_req_out", 32'(req_out), 32'd1);
        check("lat_data_out", 32'(data_out), 32'hA5);
        req_in   = 1'b0;
        sink_max = 0;
        sink_en  = 1'b1;
        wait_got(g0 + 1, "single_count");
        if (got.size() > g0) check("single_data", 32'(got[g0]), 32'hA5);
        cycles(6);
        check("single_ctrl_pulses", 32'(ctrl_cnt - c0), 32'd1);
        sink_en = 1'b0;

        // Fill with downstream stalled
        for (int i = 1; i <= 4; i++) send(8'(i), 0);
`ifdef CTRL_PIPE_STATUS_EN
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd4);
`endif
        c0 = ctrl_cnt;
        req_in  = 1'b1;
        data_in = 8'h05;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            check("full_stall_ack_in", 32'(ack_in), 32'd0);
        end
        req_in = 1'b0;
        cycles(1);
        req_in  = 1'b1;
        data_in = 8'h06;
        cycles(1);
        req_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("pulse_ack_in", 32'(ack_in), 32'd0);
            check("pulse_ctrl_out", 32'(ctrl_out), 32'd0);
        end
        check("full_no_write", 32'(ctrl_cnt - c0), 32'd0);

        // Drain in order
        g0 = got.size();
        sink_en = 1'b1;
        wait_got(g0 + 4, "drain_count");
        exp_fill = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++)
            if (got.size() > g0 + i) check("drain_order", 32'(got[g0+i]), 32'(exp_fill[i]));
        cycles(6);
        check("drain_idle_req_out", 32'(req_out), 32'd0);
`ifdef CTRL_PIPE_STATUS_EN
        check("drain_empty", 32'(empty), 32'd1);
`endif

        // Random stream with pointer wrap
        sink_max = 3;
        g0 = got.size();
        c0 = ctrl_cnt;
        sent.delete();
        for (int i = 0; i < 10; i++) begin
            sent.push_back(8'($urandom_range(0, 255)));
            send(sent[i], 3);
        end
        wait_got(g0 + 10, "stream_count");
        for (int i = 0; i < 10; i++)
            if (got.size() > g0 + i) check("stream_order", 32'(got[g0+i]), 32'(sent[i]));
        check("stream_pushes", 32'(ctrl_cnt - c0), 32'd10);
        check("max_occupancy", 32'(max_occ <= DEPTH), 32'd1);
        cycles(10);
        sink_en = 1'b0;

        // Reset with two words buffered
        send(8'h3C, 0);
        send(8'hC3, 0);
        cycles(1);
        rst = 1'b1;
        cycles(1);
        check("midrst_ack_in", 32'(ack_in), 32'd0);
        check("midrst_req_out", 32'(req_out), 32'd0);
`ifdef CTRL_PIPE_STATUS_EN
        check("midrst_level", 32'(level), 32'd0);
`endif
        rst = 1'b0;
        cycles(1);
        g0 = got.size();
        sink_max = 0;
        sink_en  = 1'b1;
        send(8'h77, 0);
        wait_got(g0 + 1, "post_rst_count");
        if (got.size() > g0) check("post_rst_first", 32'(got[g0]), 32'h77);
        cycles(8);
        check("post_rst_no_stale", 32'(got.size()), 32'(g0 + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
